// File: rtl/cp0_exc_unit.sv
// MEM-stage coprocessor-0: SR/Cause/EPC/PrID, interrupt-vs-exception arbitration,
// mfc0/mtc0 access and eret handling for the pipelined MIPS core.
module cp0_exc_unit #(
  parameter logic [31:0] PRID       = 32'h4D495053,
  parameter logic [31:0] HANDLER_PC = 32'h00004180
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] pc_mem,
  input  logic [4:0]  exccode_mem,
  input  logic        delay_mem,
  input  logic [5:0]  hwint,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_din,
  input  logic        cp0_we,
  input  logic        eret,
  output logic [31:0] cp0_dout,
  output logic        exc_req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exccode;
  logic [31:0] epc;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [31:0] victim_pc;

  assign sr_word    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
  assign cause_word = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exccode, 2'b0};

  // Interrupts use the registered IP copy, so a hwint edge reaches exc_req one cycle later.
  assign int_pend = (|(cause_ip & sr_im)) & sr_ie & ~sr_exl;
  assign exc_pend = (exccode_mem != 5'd0) & ~sr_exl;
  assign exc_req  = ~Reset & (int_pend | exc_pend);

  // A faulting delay-slot instruction restarts at its branch.
  assign victim_pc = delay_mem ? (pc_mem - 32'd4) : pc_mem;

  assign handler_pc = HANDLER_PC;
  assign epc_out    = epc;

  always_comb begin
    cp0_dout = 32'b0;
    case (cp0_addr)
      ADDR_SR:    cp0_dout = sr_word;
      ADDR_CAUSE: cp0_dout = cause_word;
      ADDR_EPC:   cp0_dout = epc;
      ADDR_PRID:  cp0_dout = PRID;
      default:    cp0_dout = 32'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sr_im  <= 6'b0;
      sr_exl <= 1'b0;
      sr_ie  <= 1'b0;
    end else if (exc_req) begin
      sr_exl <= 1'b1;
    end else begin
      if (cp0_we && cp0_addr == ADDR_SR) begin
        sr_im  <= cp0_din[15:10];
        sr_exl <= cp0_din[1];
        sr_ie  <= cp0_din[0];
      end
      // eret clears EXL even when the same edge writes SR.
      if (eret) begin
        sr_exl <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cause_bd      <= 1'b0;
      cause_ip      <= 6'b0;
      cause_exccode <= 5'b0;
    end else begin
      cause_ip <= hwint;
      if (exc_req) begin
        cause_bd      <= delay_mem;
        cause_exccode <= int_pend ? 5'd0 : exccode_mem;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      epc <= 32'b0;
    end else if (exc_req) begin
      epc <= victim_pc & ~32'h3;
    end else if (cp0_we && cp0_addr == ADDR_EPC) begin
      epc <= cp0_din & ~32'h3;
    end
  end

endmodule
